load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request at a time from the core datapath and computes the effective address.
- Checks alignment and width legality, then drives the memory strobes for exactly one cycle.
- Captures the memory's synchronous read data and returns a single response to the core through a valid/ready handshake.
- Sits between the execute stage and the byte-addressed data memory. Sign and zero extension are done by the memory; this block passes rdata through unchanged.

Parameters:
- REG_WIDTH, 64, datapath width of addresses, store data and load data.
- ALIGN_CHECK, 1, 1 = misaligned access faults with no memory access; 0 = misaligned access is issued to memory unchanged.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  block can accept a request (IDLE only).
- req_is_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3: [1:0] size (0=B, 1=H, 2=W, 3=D), [2] unsigned.
- req_base  input  REG_WIDTH  rs1 value.
- req_offset  input  REG_WIDTH  sign-extended immediate.
- req_wdata  input  REG_WIDTH  rs2 value (stores).
- resp_valid  output  1  response available.
- resp_ready  input  1  core consumes response.
- resp_data  output  REG_WIDTH  load result; 0 for stores and faults.
- resp_fault  output  1  request was not performed.
- resp_cause  output  2  01 = misaligned, 10 = illegal width, 00 = none.
- resp_addr  output  REG_WIDTH  effective address of the request.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- MemSign  output  1  1 = zero-extend, 0 = sign-extend (equals funct3[2]).
- MemWidth  output  2  access size (equals funct3[1:0]).
- wdata  output  REG_WIDTH  store data to memory.
- full_addr  output  REG_WIDTH  effective address to memory.
- rdata  input  REG_WIDTH  memory read data; valid the cycle after MemRead is sampled.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: state = IDLE. All outputs are 0 except req_ready = 1.
- Reset mid-operation aborts immediately: no further strobes and no response.
- States:
  - IDLE: req_ready = 1. On req_valid, register the request with addr = req_base + req_offset, truncated to REG_WIDTH (wrap-around, no overflow flag).
  - IDLE exit: if faulted, go to RESP; otherwise go to ISSUE.
- Illegal width: store with funct3[2] = 1, or load with funct3 = 3'b111. Cause = 10. The illegal check takes priority over misalignment.
- Misaligned (ALIGN_CHECK = 1 only): addr is not a multiple of 1 << funct3[1:0], i.e. H: addr[0] != 0; W: addr[1:0] != 0; D: addr[2:0] != 0. Cause = 01.
- ISSUE (1 cycle):
  - MemRead = !is_store, MemWrite = is_store.
  - MemWidth, MemSign, full_addr and wdata are taken from the registered request.
  - Load goes to CAPTURE; store goes to RESP.
- CAPTURE (1 cycle): resp_data <= rdata; go to RESP.
- RESP: resp_valid = 1. resp_data, resp_fault, resp_cause and resp_addr are held stable until resp_ready. On resp_ready, go to IDLE and clear resp_valid.
- Back-to-back: the next request can be accepted no earlier than the cycle after the response handshake.
- Strobes: MemRead and MemWrite are high only in ISSUE, never both at once, and never during RESP or for faulted requests. full_addr, wdata, MemWidth and MemSign may hold their values outside ISSUE.
- Latency, counted from the accept edge to the first resp_valid cycle:
  - load: 3 cycles;
  - store: 2 cycles;
  - fault: 1 cycle.
- Response contents: store responses have resp_data = 0. Faulted responses have resp_data = 0 and resp_addr = the computed address.

Test Plan:
- Store then load: sd 0x1122334455667788 at base 0x100, offset 0x8. MemWrite is high for one cycle with full_addr = 0x108 and MemWidth = 3. Then ld from the same address: resp_data = 0x1122334455667788 three cycles after accept, resp_fault = 0.
- Signed and unsigned byte: sb 0x80 at 0x20. lb gives 0xFFFFFFFFFFFFFF80 with MemSign = 0; lbu gives 0x80 with MemSign = 1.
- Misaligned: lw at base 0x101, offset 0. resp_fault = 1, resp_cause = 01, resp_addr = 0x101 one cycle after accept; MemRead is never asserted. Repeat with ALIGN_CHECK = 0: the access is issued normally with no fault.
- Illegal width: store with funct3 = 3'b100 gives cause 10 and no MemWrite. Load with funct3 = 3'b111 also gives cause 10.
- Backpressure and wrap: hold resp_ready = 0 for 5 cycles; resp_valid and resp_data stay stable and req_ready stays 0. Base 0xFFFFFFFFFFFFFFF8 with offset 0x10 gives full_addr = 0x8.
- Reset in ISSUE: deassert rst_n while MemRead = 1. All strobes drop asynchronously, there is no resp_valid after reset release, and req_ready = 1.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store initiator: computes the effective address, checks width and alignment,
// strobes the data memory for one cycle and returns a single response via valid/ready.
module load_store_unit #(
  parameter int unsigned REG_WIDTH   = 64,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_is_store,
  input  logic [2:0]           req_funct3,
  input  logic [REG_WIDTH-1:0] req_base,
  input  logic [REG_WIDTH-1:0] req_offset,
  input  logic [REG_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [REG_WIDTH-1:0] resp_data,
  output logic                 resp_fault,
  output logic [1:0]           resp_cause,
  output logic [REG_WIDTH-1:0] resp_addr,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 MemSign,
  output logic [1:0]           MemWidth,
  output logic [REG_WIDTH-1:0] wdata,
  output logic [REG_WIDTH-1:0] full_addr,
  input  logic [REG_WIDTH-1:0] rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t               state, state_nx;
  logic                 is_store_q;
  logic [2:0]           funct3_q;
  logic [REG_WIDTH-1:0] addr_q, wdata_q, data_q;
  logic                 fault_q;
  logic [1:0]           cause_q;

  logic [REG_WIDTH-1:0] eff_addr;
  logic                 illegal, misaligned, accept;

  assign eff_addr = req_base + req_offset;
  assign illegal  = req_is_store ? req_funct3[2] : (req_funct3 == 3'b111);
  assign accept   = (state == IDLE) && req_valid;

  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = eff_addr[0];
      2'd2:    misaligned = |eff_addr[1:0];
      default: misaligned = |eff_addr[2:0];
    endcase
    if (!ALIGN_CHECK) misaligned = 1'b0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = (illegal || misaligned) ? RESP : ISSUE;
      ISSUE:   state_nx = is_store_q ? RESP : CAPTURE;
      CAPTURE: state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      fault_q    <= 1'b0;
      cause_q    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        is_store_q <= req_is_store;
        funct3_q   <= req_funct3;
        addr_q     <= eff_addr;
        wdata_q    <= req_wdata;
        data_q     <= '0;
        fault_q    <= illegal || misaligned;
        // illegal width outranks misalignment
        cause_q    <= illegal ? 2'b10 : (misaligned ? 2'b01 : 2'b00);
      end
      if (state == CAPTURE) data_q <= rdata;
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_data  = data_q;
  assign resp_fault = fault_q;
  assign resp_cause = cause_q;
  assign resp_addr  = addr_q;
  assign MemRead    = (state == ISSUE) && !is_store_q;
  assign MemWrite   = (state == ISSUE) && is_store_q;
  assign MemSign    = funct3_q[2];
  assign MemWidth   = funct3_q[1:0];
  assign wdata      = wdata_q;
  assign full_addr  = addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed memory responder, latency-based reference
// model with per-cycle compare, directed literal cases and randomized traffic.
module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_valid2, req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_base, req_offset, req_wdata;
  logic        resp_ready, resp_ready2;
  logic [63:0] rdata0, rdata1;

  logic        rr0, rv0, flt0, rd0, wr0, sg0;
  logic [1:0]  cs0, wd0;
  logic [63:0] dat0, radr0, wdat0, adr0;
  logic        rr1, rv1, flt1, rd1, wr1, sg1;
  logic [1:0]  cs1, wd1;
  logic [63:0] dat1, radr1, wdat1, adr1;

  load_store_unit #(.REG_WIDTH(64), .ALIGN_CHECK(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr0),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_base(req_base),
    .req_offset(req_offset), .req_wdata(req_wdata), .resp_valid(rv0),
    .resp_ready(resp_ready), .resp_data(dat0), .resp_fault(flt0), .resp_cause(cs0),
    .resp_addr(radr0), .MemRead(rd0), .MemWrite(wr0), .MemSign(sg0), .MemWidth(wd0),
    .wdata(wdat0), .full_addr(adr0), .rdata(rdata0));

  load_store_unit #(.REG_WIDTH(64), .ALIGN_CHECK(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(rr1),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_base(req_base),
    .req_offset(req_offset), .req_wdata(req_wdata), .resp_valid(rv1),
    .resp_ready(resp_ready2), .resp_data(dat1), .resp_fault(flt1), .resp_cause(cs1),
    .resp_addr(radr1), .MemRead(rd1), .MemWrite(wr1), .MemSign(sg1), .MemWidth(wd1),
    .wdata(wdat1), .full_addr(adr1), .rdata(rdata1));

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Byte memory; key space 0/1 = memories behind dut0/dut1, 2 = reference model.
  logic [7:0] mem [logic [65:0]];

  function automatic logic [63:0] mrd(input logic [1:0] sp, input logic [63:0] a,
                                      input logic [1:0] sz, input logic u);
    logic [63:0] v;
    int n;
    v = '0;
    n = 1 << sz;
    for (int i = 0; i < n; i++) begin
      logic [65:0] key;
      key = {sp, a + 64'(i)};
      v[8*i +: 8] = mem.exists(key) ? mem[key] : 8'h00;
    end
    if (!u && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v;
  endfunction

  task automatic mwr(input logic [1:0] sp, input logic [63:0] a, input logic [1:0] sz,
                     input logic [63:0] d);
    for (int i = 0; i < (1 << sz); i++) mem[{sp, a + 64'(i)}] = d[8*i +: 8];
  endtask

  // Memory responder: read data valid only in the cycle after MemRead, junk otherwise.
  logic [63:0] pend0, pend1;
  bit hp0 = 1'b0, hp1 = 1'b0;
  initial forever begin
    @(negedge clk);
    rdata0 = hp0 ? pend0 : {$urandom, $urandom};
    hp0 = rd0;
    if (rd0) pend0 = mrd(2'd0, adr0, wd0, sg0);
    if (wr0) mwr(2'd0, adr0, wd0, wdat0);
    rdata1 = hp1 ? pend1 : {$urandom, $urandom};
    hp1 = rd1;
    if (rd1) pend1 = mrd(2'd1, adr1, wd1, sg1);
    if (wr1) mwr(2'd1, adr1, wd1, wdat1);
  end

  // Reference model of dut0: outcome decided at accept, then timed by a latency count.
  bit          m_busy = 1'b0;
  int          m_k, m_lat;
  logic        m_fault, m_st;
  logic [1:0]  m_cause;
  logic [2:0]  m_f3;
  logic [63:0] m_addr, m_data, m_wd;

  task automatic model_accept();
    logic [63:0] a;
    logic ill, mis;
    a   = req_base + req_offset;
    ill = req_is_store ? req_funct3[2] : (req_funct3 == 3'b111);
    mis = (a % (64'd1 << req_funct3[1:0])) != 64'd0;
    m_fault = ill || mis;
    m_cause = ill ? 2'b10 : (mis ? 2'b01 : 2'b00);
    m_lat   = m_fault ? 1 : (req_is_store ? 2 : 3);
    m_addr  = a;
    m_st    = req_is_store;
    m_f3    = req_funct3;
    m_wd    = req_wdata;
    m_data  = '0;
    if (!m_fault) begin
      if (m_st) mwr(2'd2, a, m_f3[1:0], m_wd);
      else      m_data = mrd(2'd2, a, m_f3[1:0], m_f3[2]);
    end
    m_busy = 1'b1;
    m_k    = 1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) m_busy = 1'b0;
    else if (m_busy) begin
      if (m_k >= m_lat && resp_ready) m_busy = 1'b0;
      else m_k++;
    end else if (req_valid) model_accept();
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      logic erv, erd, ewr;
      erv = m_busy && m_k >= m_lat;
      erd = m_busy && m_k == 1 && !m_fault && !m_st;
      ewr = m_busy && m_k == 1 && !m_fault && m_st;
      chk("req_ready", 64'(rr0), 64'(!m_busy));
      chk("resp_valid", 64'(rv0), 64'(erv));
      chk("MemRead", 64'(rd0), 64'(erd));
      chk("MemWrite", 64'(wr0), 64'(ewr));
      if (erd || ewr) begin
        chk("full_addr", adr0, m_addr);
        chk("MemWidth", 64'(wd0), 64'(m_f3[1:0]));
        chk("MemSign", 64'(sg0), 64'(m_f3[2]));
        if (ewr) chk("wdata", wdat0, m_wd);
      end
      if (erv) begin
        chk("resp_data", dat0, m_data);
        chk("resp_fault", 64'(flt0), 64'(m_fault));
        chk("resp_cause", 64'(cs0), 64'(m_cause));
        chk("resp_addr", radr0, m_addr);
      end
    end
  end

  // Observation of whichever instance the current transaction targets.
  logic        sel = 1'b0;
  logic        o_rd, o_wr, o_rv, o_rr, o_flt, o_sg;
  logic [1:0]  o_cs, o_wd;
  logic [63:0] o_dat, o_adr, o_radr;
  always_comb begin
    o_rd   = sel ? rd1   : rd0;
    o_wr   = sel ? wr1   : wr0;
    o_rv   = sel ? rv1   : rv0;
    o_rr   = sel ? rr1   : rr0;
    o_flt  = sel ? flt1  : flt0;
    o_sg   = sel ? sg1   : sg0;
    o_cs   = sel ? cs1   : cs0;
    o_wd   = sel ? wd1   : wd0;
    o_dat  = sel ? dat1  : dat0;
    o_adr  = sel ? adr1  : adr0;
    o_radr = sel ? radr1 : radr0;
  end

  int          t_lat, t_rd, t_wr;
  logic        t_stable, t_flt, t_sg;
  logic [1:0]  t_cs, t_wd;
  logic [63:0] t_dat, t_iadr, t_radr;

  // Entered just after a rising edge with the target idle; returns just after the handshake edge.
  task automatic txn(input logic s, input logic st, input logic [2:0] f3,
                     input logic [63:0] b, input logic [63:0] o, input logic [63:0] wd,
                     input int hold);
    bit got;
    sel = s;
    req_is_store = st; req_funct3 = f3; req_base = b; req_offset = o; req_wdata = wd;
    if (s) req_valid2 = 1'b1; else req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid2 = 1'b0;
    t_lat = 0; t_rd = 0; t_wr = 0; t_stable = 1'b1; got = 1'b0;
    t_sg = 1'b0; t_wd = '0; t_iadr = '0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (o_rd) begin t_rd++; t_iadr = o_adr; t_wd = o_wd; t_sg = o_sg; end
      if (o_wr) begin t_wr++; t_iadr = o_adr; t_wd = o_wd; end
      if (t_lat == 0 && o_rv) begin
        t_lat = k; t_dat = o_dat; t_flt = o_flt; t_cs = o_cs; t_radr = o_radr;
      end else if (t_lat != 0)
        t_stable = t_stable && o_rv && !o_rr && (o_dat == t_dat);
      if (t_lat != 0 && k >= t_lat + hold) begin
        got = 1'b1;
        if (s) resp_ready2 = 1'b1; else resp_ready = 1'b1;
      end else if (!s) begin
        // request noise while busy must be ignored
        req_valid    = 1'($urandom_range(0, 1));
        req_is_store = 1'($urandom_range(0, 1));
        req_funct3   = 3'($urandom_range(0, 7));
        req_base     = {$urandom, $urandom};
      end
    end
    chk("resp_timeout", 64'(got), 64'd1);
    @(posedge clk); #1;
    resp_ready = 1'b0; resp_ready2 = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        st;
    logic [2:0]  f3;
    logic [63:0] b, o;
    rst_n = 1'b0; req_valid = 1'b0; req_valid2 = 1'b0; resp_ready = 1'b0; resp_ready2 = 1'b0;
    req_is_store = 1'b0; req_funct3 = '0; req_base = '0; req_offset = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(rr0), 64'd1);
    chk("rst_resp_valid", 64'(rv0), 64'd0);
    chk("rst_strobes", 64'({rd0, wr0, sg0, wd0, flt0, cs0}), 64'd0);
    chk("rst_data_addr", dat0 | radr0 | adr0 | wdat0, 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    txn(1'b0, 1'b1, 3'd3, 64'h100, 64'h8, 64'h1122334455667788, 0);
    chk("sd_write_once", 64'(t_wr), 64'd1);
    chk("sd_addr", t_iadr, 64'h108);
    chk("sd_width", 64'(t_wd), 64'd3);
    chk("sd_latency", 64'(t_lat), 64'd2);
    chk("sd_resp_data", t_dat, 64'd0);
    txn(1'b0, 1'b0, 3'd3, 64'h100, 64'h8, 64'h0, 0);
    chk("ld_latency", 64'(t_lat), 64'd3);
    chk("ld_data", t_dat, 64'h1122334455667788);
    chk("ld_fault", 64'(t_flt), 64'd0);

    txn(1'b0, 1'b1, 3'd0, 64'h20, 64'h0, 64'h80, 1);
    txn(1'b0, 1'b0, 3'd0, 64'h20, 64'h0, 64'h0, 0);
    chk("lb_data", t_dat, 64'hFFFFFFFFFFFFFF80);
    chk("lb_sign", 64'(t_sg), 64'd0);
    txn(1'b0, 1'b0, 3'd4, 64'h20, 64'h0, 64'h0, 2);
    chk("lbu_data", t_dat, 64'h80);
    chk("lbu_sign", 64'(t_sg), 64'd1);

    txn(1'b0, 1'b0, 3'd2, 64'h101, 64'h0, 64'h0, 0);
    chk("mis_latency", 64'(t_lat), 64'd1);
    chk("mis_fault_cause", 64'({t_flt, t_cs}), 64'b101);
    chk("mis_addr", t_radr, 64'h101);
    chk("mis_no_read", 64'(t_rd), 64'd0);

    txn(1'b0, 1'b1, 3'd4, 64'h40, 64'h0, 64'hDEAD, 0);
    chk("ill_st_cause", 64'({t_flt, t_cs}), 64'b110);
    chk("ill_st_no_write", 64'(t_wr), 64'd0);
    txn(1'b0, 1'b0, 3'd7, 64'h40, 64'h0, 64'h0, 0);
    chk("ill_ld_cause", 64'({t_flt, t_cs}), 64'b110);
    chk("ill_ld_no_read", 64'(t_rd), 64'd0);

    txn(1'b0, 1'b0, 3'd3, 64'hFFFFFFFFFFFFFFF8, 64'h10, 64'h0, 5);
    chk("wrap_addr", t_iadr, 64'h8);
    chk("bp_stable", 64'(t_stable), 64'd1);

    txn(1'b1, 1'b1, 3'd3, 64'h100, 64'h0, 64'h1122334455667788, 0);
    txn(1'b1, 1'b0, 3'd2, 64'h101, 64'h0, 64'h0, 0);
    chk("noalign_read", 64'(t_rd), 64'd1);
    chk("noalign_addr", t_iadr, 64'h101);
    chk("noalign_latency", 64'(t_lat), 64'd3);
    chk("noalign_fault", 64'(t_flt), 64'd0);
    chk("noalign_data", t_dat, 64'h0000000044556677);

    for (int i = 0; i < 300; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (st && $urandom_range(0, 3) != 0) f3[2] = 1'b0;
      b = 64'h1000 + 64'($urandom_range(0, 7)) * 64'd8;
      if ($urandom_range(0, 15) == 0) b = 64'hFFFFFFFFFFFFFFF0;
      o = 64'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) o = -64'($urandom_range(0, 16));
      if ($urandom_range(0, 2) != 0) o = o & ~64'h7;
      txn(1'b0, st, f3, b, o, {$urandom, $urandom}, $urandom_range(0, 3));
    end

    sel = 1'b0;
    req_is_store = 1'b0; req_funct3 = 3'd3; req_base = 64'h100; req_offset = 64'h8;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstiss_read_before", 64'(rd0), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstiss_strobes", 64'({rd0, wr0}), 64'd0);
    chk("rstiss_resp_valid", 64'(rv0), 64'd0);
    chk("rstiss_req_ready", 64'(rr0), 64'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_resp", 64'({rv0, rd0, wr0}), 64'd0);
      chk("post_rst_ready", 64'(rr0), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
